// File: rtl/file_collecter.sv
// file_collecter: packs a byte stream into little-endian words, buffers them, dumps them at end of stream (trace: COLLECTER_TRACE_EN)
module file_collecter #(
  parameter  int BIT_WIDTH = 32,
  parameter  int DEPTH     = 256,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [CW-1:0]        count,
  output logic                 done,
  output logic                 overflow,
  input  logic                 start
);
  localparam int NB = BIT_WIDTH / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {COLLECT, DUMP, DONE} state_t;
  state_t state, state_nxt;
  logic [BIT_WIDTH-1:0] mem [DEPTH];
  logic [BIT_WIDTH-1:0] asm_q, word;
  logic [BW-1:0] byte_idx;
  logic [CW-1:0] rd_ptr, cnt_after;
  logic accept, complete, full, store, fire;
  // handshake decode and the word as it looks with the incoming byte merged in
  always_comb begin
    accept = in_valid && in_ready;
    complete = accept && byte_idx == BW'(NB - 1);
    full = count == CW'(DEPTH);
    store = complete && !full;
    cnt_after = count + CW'(store);
    fire = out_valid && out_ready;
    word = asm_q;
    word[{byte_idx, 3'b000} +: 8] = in_data;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= COLLECT;
    else state <= state_nxt;
  // next state: end of stream dumps only if something was stored
  always_comb
    state_nxt = state == COLLECT ? (accept && in_last ? (cnt_after != '0 ? DUMP : DONE) : COLLECT) :
                state == DUMP    ? (fire && out_last ? DONE : DUMP) :
                                   (start ? COLLECT : DONE);
  // outputs decoded from state; dump data read straight from the buffer so it holds while stalled
  always_comb begin
    in_ready = state == COLLECT;
    out_valid = state == DUMP;
    out_data = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    out_last = out_valid && rd_ptr == count - CW'(1);
    done = state == DONE;
  end
  // assembly, word count, overflow flag and read pointer; partial words are dropped on in_last
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      asm_q <= '0;
      byte_idx <= '0;
      count <= '0;
      overflow <= 1'b0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        asm_q <= word;
        byte_idx <= (complete || in_last) ? '0 : byte_idx + BW'(1);
      end
      if (store) count <= cnt_after;
      if (complete && full) overflow <= 1'b1;
      if (fire) rd_ptr <= rd_ptr + CW'(1);
      if (done && start) begin
        count <= '0;
        rd_ptr <= '0;
        byte_idx <= '0;
        overflow <= 1'b0;
      end
    end
  // word storage, no reset needed
  always_ff @(posedge clk)
    if (store) mem[count[AW-1:0]] <= word;
`ifdef COLLECTER_TRACE_EN
  // simulation trace of stored words, end of stream and dumped words
  always_ff @(posedge clk) begin
    if (store) $display("Read data: 0x%x", word);
    if (accept && in_last) $display("End of file reached or read error.");
    if (fire) $display("Dump word %0d: 0x%x", rd_ptr, out_data);
  end
`endif
endmodule

// File: tb/tb_file_collecter.sv
// tb_file_collecter: scoreboard bench for a 32-bit/256-deep and an 8-bit/4-deep collector
module tb_file_collecter;
  logic clk = 0, rst = 1, sel = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0, start = 0;
  logic [7:0] in_data = 0;
  logic a_ir, a_ov, a_ol, a_dn, a_ovf, b_ir, b_ov, b_ol, b_dn, b_ovf;
  logic [31:0] a_od;
  logic [7:0] b_od;
  logic [8:0] a_cnt;
  logic [2:0] b_cnt;
  logic [31:0] od;
  logic [8:0] cnt;
  logic ir, ov, ol, dn, ovf;
  int n_tests = 0, n_fail = 0;
  int m_idx = 0, m_cnt = 0;
  bit m_ovf = 0;
  logic [31:0] m_word = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  file_collecter #(.BIT_WIDTH(32), .DEPTH(256)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(a_ir), .in_data(in_data),
    .in_last(in_last), .out_valid(a_ov), .out_ready(out_ready & ~sel), .out_data(a_od),
    .out_last(a_ol), .count(a_cnt), .done(a_dn), .overflow(a_ovf), .start(start & ~sel)
  );
  file_collecter #(.BIT_WIDTH(8), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(b_ir), .in_data(in_data),
    .in_last(in_last), .out_valid(b_ov), .out_ready(out_ready & sel), .out_data(b_od),
    .out_last(b_ol), .count(b_cnt), .done(b_dn), .overflow(b_ovf), .start(start & sel)
  );

  assign od = sel ? {24'b0, b_od} : a_od;
  assign cnt = sel ? {6'b0, b_cnt} : a_cnt;
  assign ir = sel ? b_ir : a_ir;
  assign ov = sel ? b_ov : a_ov;
  assign ol = sel ? b_ol : a_ol;
  assign dn = sel ? b_dn : a_dn;
  assign ovf = sel ? b_ovf : a_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_idx = 0; m_cnt = 0; m_ovf = 0; m_word = 0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    int nb, dep;
    nb = sel ? 1 : 4;
    dep = sel ? 4 : 256;
    @(negedge clk);
    in_valid = 1; in_data = d; in_last = last;
    #1 check("in_ready", ir, 1);
    @(posedge clk);
    m_word[8*m_idx +: 8] = d;
    if (m_idx == nb - 1) begin
      if (m_cnt < dep) begin
        exp_q.push_back(m_word);
        m_cnt++;
      end else m_ovf = 1;
      m_idx = 0;
      m_word = 0;
    end else m_idx++;
    if (last) begin
      m_idx = 0;
      m_word = 0;
    end
    #1 in_valid = 0; in_last = 0;
    if (last) begin
      check("count", cnt, m_cnt);
      check("overflow", ovf, m_ovf);
      check("dumping", ov, m_cnt > 0);
      check("in_ready_off", ir, 0);
    end
  endtask

  task automatic drain(input logic [3:0] pat);
    logic [31:0] held = 0, e;
    bit stalled = 0;
    for (int i = 0; i < 200 && !dn; i++) begin
      @(negedge clk);
      out_ready = pat[i % 4];
      #1;
      if (ov) begin
        if (stalled) check("stable", od, held);
        if (out_ready) begin
          if (exp_q.size() == 0) check("extra_word", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("data", od, e);
            check("last", ol, exp_q.size() == 0);
          end
          stalled = 0;
        end else begin
          held = od;
          stalled = 1;
        end
      end
    end
    check("done", dn, 1);
    check("all_dumped", exp_q.size(), 0);
    check("count_held", cnt, m_cnt);
    out_ready = 0;
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    model_clear();
    check("rs_done", dn, 0);
    check("rs_count", cnt, 0);
    check("rs_overflow", ovf, 0);
    check("rs_in_ready", ir, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, ir, 1);
    check({tag, "_out_valid"}, ov, 0);
    check({tag, "_out_last"}, ol, 0);
    check({tag, "_out_data"}, od, 0);
    check({tag, "_count"}, cnt, 0);
    check({tag, "_done"}, dn, 0);
    check({tag, "_overflow"}, ovf, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_reset_vals("reset_a");
    sel = 1; #1 check_reset_vals("reset_b");
    sel = 0;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    drain(4'b1111);
    restart();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h11, 0); send(8'h22, 1);
    drain(4'b1111);
    restart();
    send(8'h5A, 1);
    check("single_done", dn, 1);
    check("single_no_valid", ov, 0);
    drain(4'b1111);
    restart();
    for (int i = 0; i < 12; i++) send(8'($urandom_range(0, 255)), i == 11);
    drain(4'b1001);
    restart();
    for (int i = 0; i < 8; i++) send(8'(8'h40 + i), i == 7);
    @(negedge clk);
    #2 rst = 1;
    #1 check_reset_vals("mid_dump_rst");
    @(negedge clk);
    rst = 0;
    model_clear();
    send(8'h5A, 1);
    restart();
    send(8'h31, 0); send(8'h32, 0);
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 3; i <= 8; i++) send(8'(8'h30 + i), i == 8);
    drain(4'b1111);
    restart();
    sel = 1;
    #1;
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i), i == 5);
    check("ovf_set", ovf, 1);
    drain(4'b1101);
    check("ovf_sticky", ovf, 1);
    restart();
    send(8'h20, 0); send(8'h21, 1);
    drain(4'b1111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
